// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and the MEM-stage MMIO decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    // Arbiter FSM: IDLE selects the owner each cycle, ACK returns the DBG completion pulse.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } arb_state_t;

    // LED/SW register address; accesses here are MMIO and never reach data memory.
    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating count of consecutive cycles a DBG request lost arbitration to the CPU.
// Latency: count updates on the clock edge; sat_o is a decode of the registered count.
// Backpressure: none; clear has priority over increment.
// Ports: clk/nReset, clr_i (restart count), inc_i (one more blocked cycle),
//        sat_o (count has reached MAX_WAIT).
// Only built when DMEM_ARB_STARVE_EN is defined.
`ifdef DMEM_ARB_STARVE_EN
module dmem_arb_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic nReset,
    input  logic clr_i,
    input  logic inc_i,
    output logic sat_o
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] SAT_VAL = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == SAT_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (CPU) and a debug/boot-load port (DBG).
// Latency: CPU zero added latency (combinational mux); DBG ack and read data one cycle after grant.
// Backpressure: DBG waits on dbg_req until dbg_ack; CPU stalled only in a forced DBG slot.
// Ports: clk/nReset; cpu_* MEM-stage request and load data plus cpu_stall;
//        dbg_* request/ack port with registered read data; mem_* to the data memory.
// Config: DMEM_ARB_STARVE_EN enables the starvation guard (forced DBG slot after MAX_WAIT
//         blocked cycles); without it DBG is served only in cycles the CPU leaves memory idle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  cpu_R_En,
    input  logic                  cpu_W_En,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_ack,
    output logic                  mem_R_En,
    output logic                  mem_W_En,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t            state_q, state_d;
    logic                  dbg_ack_q, dbg_ack_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

    logic cpu_mem_req;
    logic in_idle;
    logic force_slot;
    logic dbg_grant;

    // The MMIO address is decoded by the MEM stage itself, so it must not occupy memory.
    assign cpu_mem_req = (cpu_R_En || cpu_W_En) && (cpu_addr != MMIO_ADDR);
    assign in_idle     = (state_q == S_IDLE);
    assign dbg_grant   = in_idle && dbg_req && (!cpu_mem_req || force_slot);

`ifdef DMEM_ARB_STARVE_EN
    logic wait_sat;
    logic wait_clr;
    logic wait_inc;

    // Counter only moves in IDLE; in ACK it holds the zero written at grant time.
    assign force_slot = in_idle && dbg_req && wait_sat;
    assign wait_clr   = in_idle && (!dbg_req || dbg_grant);
    assign wait_inc   = in_idle && dbg_req && cpu_mem_req && !force_slot;

    dmem_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .nReset (nReset),
        .clr_i  (wait_clr),
        .inc_i  (wait_inc),
        .sat_o  (wait_sat)
    );

    // A grant while the CPU also wants memory can only be a forced slot; the CPU
    // access is dropped this cycle and the frozen pipeline reissues it next cycle.
    assign cpu_stall = dbg_grant && cpu_mem_req;
`else
    assign force_slot = 1'b0;
    assign cpu_stall  = 1'b0;
`endif

    // Memory port mux. Address/data follow the CPU when nobody is granted; the
    // enables are what keep memory untouched in that case.
    always_comb begin
        mem_R_En  = 1'b0;
        mem_W_En  = 1'b0;
        mem_addr  = cpu_addr[ADDR_WIDTH-1:0];
        mem_wdata = cpu_wdata;
        if (dbg_grant) begin
            mem_R_En  = !dbg_we;
            mem_W_En  = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_mem_req) begin
            mem_R_En  = cpu_R_En;
            mem_W_En  = cpu_W_En;
        end
    end

    assign cpu_rdata = mem_rdata;

    always_comb begin
        state_d     = state_q;
        dbg_ack_d   = 1'b0;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (dbg_grant) begin
                    state_d   = S_ACK;
                    dbg_ack_d = 1'b1;
                    if (!dbg_we) begin
                        dbg_rdata_d = mem_rdata;
                    end
                end
            end
            // dbg_req is ignored here so a held request cannot be granted back-to-back.
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
// Latency: inputs driven at negedge, combinational outputs sampled before posedge,
//          registered outputs sampled 1 time unit after posedge.
// Backpressure: DBG master model holds dbg_req until dbg_ack.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk;
    logic          nReset;
    logic          cpu_R_En, cpu_W_En;
    logic [31:0]   cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata, dbg_rdata;
    logic          dbg_ack;
    logic          mem_R_En, mem_W_En;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    dmem_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (4)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .cpu_R_En  (cpu_R_En),
        .cpu_W_En  (cpu_W_En),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .mem_R_En  (mem_R_En),
        .mem_W_En  (mem_W_En),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Data memory: combinational read, write on the clock edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_W_En) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cwd;
        logic        dq, dwe;
        logic [9:0]  da;
        logic [31:0] dwd;
        logic        er, ew;
        logic        chk_a;
        logic [9:0]  ea;
        logic [31:0] ewd;
        logic        chk_rd;
        logic [31:0] erd;
        logic        eack;
        logic [31:0] edr;
        string       name;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                         input logic dq, input logic dwe, input logic [9:0] da, input logic [31:0] dwd);
        cpu_R_En  = cr;
        cpu_W_En  = cw;
        cpu_addr  = ca;
        cpu_wdata = cwd;
        dbg_req   = dq;
        dbg_we    = dwe;
        dbg_addr  = da;
        dbg_wdata = dwd;
    endtask

    initial begin
        vecs[0]  = '{1'b0,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,10'd0,32'h0,    1'b0,1'b1, 1'b1,10'h10,32'hDEADBEEF, 1'b0,32'h0,        1'b0,32'h0,    "cpu_store"};
        vecs[1]  = '{1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,10'd0,32'h0,    1'b1,1'b0, 1'b1,10'h10,32'h0,        1'b1,32'hDEADBEEF, 1'b0,32'h0,    "cpu_load"};
        vecs[2]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b1,10'd5,32'h1234, 1'b0,1'b1, 1'b1,10'd5,32'h1234,      1'b0,32'h0,        1'b1,32'h0,    "dbg_write"};
        vecs[3]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,10'd5,32'h0,    1'b0,1'b0, 1'b0,10'd0,32'h0,         1'b0,32'h0,        1'b0,32'h0,    "ack_ignores_req"};
        vecs[4]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,10'd5,32'h0,    1'b1,1'b0, 1'b1,10'd5,32'h0,         1'b0,32'h0,        1'b1,32'h1234, "dbg_read"};
        vecs[5]  = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,10'd0,32'h0,    1'b0,1'b0, 1'b0,10'd0,32'h0,         1'b0,32'h0,        1'b0,32'h1234, "idle"};
        vecs[6]  = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,10'd5,32'h0,    1'b1,1'b0, 1'b1,10'h10,32'h0,        1'b1,32'hDEADBEEF, 1'b0,32'h1234, "cpu_wins"};
        vecs[7]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b1,10'd7,32'hA5A5, 1'b0,1'b1, 1'b1,10'd7,32'hA5A5,      1'b0,32'h0,        1'b1,32'h1234, "dbg_write_after_block"};
        vecs[8]  = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,10'd0,32'h0,    1'b0,1'b0, 1'b0,10'd0,32'h0,         1'b0,32'h0,        1'b0,32'h1234, "gap"};
        vecs[9]  = '{1'b0,1'b1,32'hFFFFFFFF,32'h55, 1'b1,1'b0,10'd7,32'h0,    1'b1,1'b0, 1'b1,10'd7,32'h0,         1'b0,32'h0,        1'b1,32'hA5A5, "mmio_store_dbg_read"};
        vecs[10] = '{1'b1,1'b0,32'h407,32'h0,       1'b0,1'b0,10'd0,32'h0,    1'b1,1'b0, 1'b1,10'd7,32'h0,         1'b1,32'hA5A5,     1'b0,32'hA5A5, "cpu_load_addr_trunc"};
        vecs[11] = '{1'b1,1'b0,32'hFFFFFFFF,32'h0,  1'b0,1'b0,10'd0,32'h0,    1'b0,1'b0, 1'b0,10'd0,32'h0,         1'b0,32'h0,        1'b0,32'hA5A5, "mmio_load_no_mem"};

        nReset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.dbg_ack",   32'(dbg_ack),   32'h0);
        chk("reset.dbg_rdata", dbg_rdata,      32'h0);
        chk("reset.cpu_stall", 32'(cpu_stall), 32'h0);
        @(negedge clk);
        nReset = 1'b1;

        // Table: one vector per cycle.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cwd,
                  vecs[i].dq, vecs[i].dwe, vecs[i].da, vecs[i].dwd);
            #2;
            chk({vecs[i].name, ".mem_R_En"},  32'(mem_R_En),  32'(vecs[i].er));
            chk({vecs[i].name, ".mem_W_En"},  32'(mem_W_En),  32'(vecs[i].ew));
            chk({vecs[i].name, ".cpu_stall"}, 32'(cpu_stall), 32'h0);
            if (vecs[i].chk_a)  chk({vecs[i].name, ".mem_addr"},  32'(mem_addr), 32'(vecs[i].ea));
            if (vecs[i].ew)     chk({vecs[i].name, ".mem_wdata"}, mem_wdata,      vecs[i].ewd);
            if (vecs[i].chk_rd) chk({vecs[i].name, ".cpu_rdata"}, cpu_rdata,      vecs[i].erd);
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".dbg_ack"},   32'(dbg_ack), 32'(vecs[i].eack));
            chk({vecs[i].name, ".dbg_rdata"}, dbg_rdata,    vecs[i].edr);
        end

        // Starvation: CPU loads every cycle while DBG reads addr 5 (holds 0x1234).
        begin
            logic got_ack;
            got_ack = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                drive(1'b1, 1'b0, 32'h10, 32'h0, !got_ack, 1'b0, 10'd5, 32'h0);
                #2;
                chk($sformatf("starve[%0d].cpu_stall", i), 32'(cpu_stall), 32'(STARVE && i == 4));
                chk($sformatf("starve[%0d].mem_addr", i),  32'(mem_addr),
                    (STARVE && i == 4) ? 32'd5 : 32'h10);
                @(posedge clk);
                #1;
                chk($sformatf("starve[%0d].dbg_ack", i), 32'(dbg_ack), 32'(STARVE && i == 4));
                if (dbg_ack) got_ack = 1'b1;
            end
            chk("starve.dbg_rdata", dbg_rdata, STARVE ? 32'h1234 : 32'hA5A5);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0);
        @(posedge clk);

        // Reset asserted in the grant cycle of a DBG read of addr 7 (0xA5A5).
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd7, 32'h0);
        #2;
        chk("rst_mid.grant_mem_R_En", 32'(mem_R_En), 32'h1);
        nReset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.dbg_ack",   32'(dbg_ack), 32'h0);
        chk("rst_mid.dbg_rdata", dbg_rdata,    32'h0);
        @(negedge clk);
        nReset  = 1'b1;
        dbg_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.no_late_ack", 32'(dbg_ack), 32'h0);
        // A fresh request is granted at once, which only happens from IDLE.
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd7, 32'h0);
        #2;
        chk("post_rst.mem_R_En", 32'(mem_R_En), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst.dbg_ack",   32'(dbg_ack), 32'h1);
        chk("post_rst.dbg_rdata", dbg_rdata,    32'hA5A5);
        @(negedge clk);
        dbg_req = 1'b0;
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the MEM pipeline stage (CPU port) and an external debug/boot-load port (DBG port). Sits between the MEM stage control signals and the data memory instance: the CPU port is served with zero added latency, the DBG port through a request/acknowledge handshake, with an optional starvation guard that briefly stalls the pipeline.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width (`WORD_LEN`)
- ADDR_WIDTH, 10, memory word-address bits driven to memory
- MAX_WAIT, 4, consecutive blocked DBG cycles before a forced DBG slot (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- nReset  in  1  asynchronous active-low reset
- cpu_R_En / cpu_W_En  in  1 each  MEM-stage read/write enables
- cpu_addr  in  32  ALU result used as address
- cpu_wdata  in  DATA_WIDTH  store data (rd2)
- cpu_rdata  out  DATA_WIDTH  load data to MEM stage (combinational pass of mem_rdata)
- cpu_stall  out  1  freeze pipeline this cycle
- dbg_req  in  1  debug request, held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_WIDTH  debug word address
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_rdata  out  DATA_WIDTH  registered read data, valid with dbg_ack
- dbg_ack  out  1  one-cycle completion pulse
- mem_R_En / mem_W_En  out  1 each  to data memory
- mem_addr  out  ADDR_WIDTH  to data memory
- mem_wdata  out  DATA_WIDTH  to data memory
- mem_rdata  in  DATA_WIDTH  from data memory (combinational read, write on clock edge)

## Operation
- cpu_mem_req = (cpu_R_En | cpu_W_En) && cpu_addr != 32'hFFFFFFFF (MMIO LED/SW address never touches memory).
- States: S_IDLE, S_ACK. Reset → S_IDLE, wait_cnt = 0, dbg_ack = 0, dbg_rdata = 0, cpu_stall = 0.
- S_IDLE, grant selection in the same cycle:
  - force = dbg_req && wait_cnt == MAX_WAIT (STARVE feature only).
  - dbg_grant = dbg_req && (!cpu_mem_req || force); otherwise CPU owns memory.
  - CPU grant: mem_* = cpu signals, mem_addr = cpu_addr[ADDR_WIDTH-1:0].
  - DBG grant: mem_* = dbg signals; dbg_rdata <= mem_rdata on read (unchanged on write); wait_cnt <= 0; next S_ACK.
  - dbg_req && cpu_mem_req && !force: wait_cnt <= wait_cnt+1, saturating at MAX_WAIT.
  - !dbg_req: wait_cnt <= 0.
- cpu_stall = dbg_grant && cpu_mem_req (only on a forced slot); the CPU access is not performed and reissues next cycle.
- S_ACK: dbg_ack = 1; dbg_req ignored; CPU owns memory unconditionally; next S_IDLE. A DBG master that keeps dbg_req high gets a new transaction no sooner than the following cycle.
- No memory enable is asserted when neither side is granted.

## Timing
- CPU: zero latency, never stalled except in forced slot (max 1 stall cycle per MAX_WAIT+2 cycles).
- DBG: grant in the cycle of request if CPU idle; dbg_ack exactly one cycle after grant; worst case MAX_WAIT+1 cycles to grant.
- dbg_ack and dbg_rdata are registered; cpu_stall, mem_*, cpu_rdata combinational.
- Reset assertion mid-transaction: pending DBG transaction dropped with no ack; a write already clocked into memory stays.

## Configuration
- DMEM_ARB_STARVE_EN defined: forced slot and cpu_stall as above.
- Undefined: force = 0, cpu_stall tied 0, wait_cnt removed; DBG served only in cycles with no CPU memory access (unbounded wait permitted).

## Structure
- Shared package: state enum arb_state_t {S_IDLE, S_ACK}, constant MMIO_ADDR = 32'hFFFFFFFF (also used by MEM-stage LED/SW decode).
- One sub-module: dmem_arb_wait_cnt (saturating wait counter with clear, compiled only under DMEM_ARB_STARVE_EN).

## Test plan
- Reset then CPU store 0xDEADBEEF to addr 0x10, load addr 0x10 → cpu_rdata 0xDEADBEEF same cycle, cpu_stall 0, dbg_ack 0.
- CPU idle, dbg write 0x1234 to addr 5 then dbg read addr 5 → dbg_ack one cycle after each grant, dbg_rdata 0x1234 with second ack.
- CPU loads every cycle, dbg_req held (STARVE_EN, MAX_WAIT=4) → cpu_stall high exactly in the 5th cycle, dbg_ack next cycle; without macro → no ack, no stall.
- CPU store to 0xFFFFFFFF with dbg_req → mem_W_En driven by DBG, no memory write from CPU, dbg_ack next cycle.
- nReset low in the grant cycle of a dbg read → dbg_ack stays 0, dbg_rdata 0, state S_IDLE after release.
